fetch_sequencer: RTL
====================

// Module: fetch_sequencer
// PURPOSE
//   Controls the program counter and the instruction-memory fetch handshake.
//   Generates the PC's hold/branch/jump controls, the imem request, IF/ID valid and flush.
//   Captures a branch/jump redirect that arrives while a fetch is outstanding and applies it once the stale fetch drains.
//   Sits between the hazard unit, the EX-stage branch/jump resolution, imem and the PC register.
// PARAMETERS
//   ADDR_W    32  width of PC offset/target values
//   MAX_WAIT  15  imem wait cycles before fetch_err is set (counter width = $clog2(MAX_WAIT+1))
// PORTS
//   clk         in   1       clock, rising edge
//   rst         in   1       reset, asynchronous, active-high
//   stall       in   1       hazard unit: freeze fetch (load-use / downstream busy)
//   br_taken    in   1       EX: branch resolved taken this cycle
//   br_offset   in   ADDR_W  EX: byte offset for taken branch
//   jmp         in   1       EX: jump this cycle
//   jmp_target  in   ADDR_W  EX: absolute jump target
//   imem_ack    in   1       imem: fetch data valid, single-cycle pulse
//   imem_req    out  1       imem: fetch request, held high until ack
//   pc_hold     out  1       PC: 1 = keep value
//   pc_branch   out  1       PC: PC <= PC + pc_offset
//   pc_jump     out  1       PC: PC <= pc_jval
//   pc_offset   out  ADDR_W  PC: branch offset
//   pc_jval     out  ADDR_W  PC: jump target
//   if_valid    out  1       IF/ID: fetched instruction is on the correct path, latch it
//   flush       out  1       pipeline flush of IF/ID and ID/EX
//   fetch_err   out  1       sticky imem timeout flag
// BEHAVIOUR
//   Reset
//     - state=S_RESET; pc_hold=1; all other outputs 0.
//     - Pending regs cleared.
//     - Reset mid-fetch abandons the fetch; an ack seen in S_RESET is ignored.
//   Outputs
//     - Outputs are combinational from state + inputs; the PC updates on the same clk edge.
//     - pc_hold=1 except where stated below.
//     - pc_branch/pc_jump are never both 1; branch beats jump.
//     - pc_offset/pc_jval pass through br_offset/jmp_target, or the pending copy in S_DRAIN; no arithmetic.
//   Redirect
//     - redirect = br_taken | jmp.
//     - Redirect has priority over stall and over a normal sequential advance.
//   States
//     - S_RESET: imem_req=0; go S_REQ next cycle unconditionally.
//     - S_REQ: imem_req=1.
//       - ack & !redirect & !stall: pc_hold=0 (PC+4); if_valid=1; stay.
//       - ack & !redirect & stall: if_valid=0; go S_STALL.
//       - ack & redirect: pc_hold=0, branch/jump selected; flush=1; if_valid=0; stay.
//       - !ack & redirect: latch kind + value into pending; flush=1; go S_DRAIN.
//     - S_STALL: imem_req=0; instruction held by the IF/ID hold path.
//       - redirect: pc_hold=0 to target; flush=1; if_valid=0; go S_REQ.
//       - !stall: pc_hold=0 (PC+4); if_valid=1; go S_REQ.
//     - S_DRAIN: imem_req=1.
//       - Redirect here overwrites pending (latest wins) and reasserts flush.
//       - ack: pc_hold=0 using pending (or same-cycle redirect); if_valid=0; clear pending; go S_REQ.
//   Timeout
//     - Counter counts consecutive cycles with imem_req=1 & !imem_ack; clears on ack.
//     - At count==MAX_WAIT, fetch_err<=1 and stays 1 until rst.
//     - The FSM is unaffected.
// TESTING
//   rst 3 cycles, release, ack every 2nd cycle -> PC steps 0,4,8,12; if_valid pulses with each ack; flush=0.
//   S_REQ: br_taken=1, br_offset=16 with ack same cycle -> pc_branch=1, pc_hold=0, flush=1, if_valid=0 that cycle.
//   jmp=1, jmp_target=0x40 with no ack, ack 3 cycles later -> S_DRAIN; pc_jump/pc_jval=0x40 only on ack; if_valid stays 0.
//   ack with stall=1, stall held 4 cycles -> pc_hold=1 and imem_req=0 for 4 cycles; on release PC+4, if_valid=1.
//   In S_STALL: br_taken=1 and jmp=1 together -> pc_branch=1, pc_jump=0, flush=1.
//   imem_ack never asserted -> fetch_err=1 after 15 waits, sticky; rst mid-wait clears it and returns to S_RESET.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: drives PC hold/branch/jump, the imem request handshake, IF/ID valid and flush.
// A redirect that arrives while a fetch is outstanding is parked until the stale fetch drains.
module fetch_sequencer #(
   parameter int ADDR_W   = 32,
   parameter int MAX_WAIT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              br_taken,
   input  logic [ADDR_W-1:0] br_offset,
   input  logic              jmp,
   input  logic [ADDR_W-1:0] jmp_target,
   input  logic              imem_ack,
   output logic              imem_req,
   output logic              pc_hold,
   output logic              pc_branch,
   output logic              pc_jump,
   output logic [ADDR_W-1:0] pc_offset,
   output logic [ADDR_W-1:0] pc_jval,
   output logic              if_valid,
   output logic              flush,
   output logic              fetch_err
);

   localparam int CNT_W = $clog2(MAX_WAIT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

   typedef enum logic [1:0] {S_RESET, S_REQ, S_STALL, S_DRAIN} state_t;

   state_t            r_state;
   state_t            w_next;
   logic              r_pend_br;
   logic [ADDR_W-1:0] r_pend_off;
   logic [ADDR_W-1:0] r_pend_jval;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_err;
   logic              w_redirect;
   logic              w_latch;
   logic              w_clear;

   assign w_redirect = br_taken | jmp;
   assign fetch_err  = r_err;

   always_comb begin
      w_next    = r_state;
      imem_req  = 1'b0;
      pc_hold   = 1'b1;
      pc_branch = 1'b0;
      pc_jump   = 1'b0;
      pc_offset = br_offset;
      pc_jval   = jmp_target;
      if_valid  = 1'b0;
      flush     = 1'b0;
      w_latch   = 1'b0;
      w_clear   = 1'b0;
      case (r_state)
         S_RESET: w_next = S_REQ;
         S_REQ: begin
            imem_req = 1'b1;
            if (imem_ack) begin
               if (w_redirect) begin
                  pc_hold   = 1'b0;
                  pc_branch = br_taken;
                  pc_jump   = ~br_taken;
                  flush     = 1'b1;
               end else if (stall) begin
                  w_next = S_STALL;
               end else begin
                  pc_hold  = 1'b0;
                  if_valid = 1'b1;
               end
            end else if (w_redirect) begin
               flush   = 1'b1;
               w_latch = 1'b1;
               w_next  = S_DRAIN;
            end
         end
         S_STALL: begin
            if (w_redirect) begin
               pc_hold   = 1'b0;
               pc_branch = br_taken;
               pc_jump   = ~br_taken;
               flush     = 1'b1;
               w_next    = S_REQ;
            end else if (!stall) begin
               pc_hold  = 1'b0;
               if_valid = 1'b1;
               w_next   = S_REQ;
            end
         end
         S_DRAIN: begin
            imem_req = 1'b1;
            // A fresh redirect supersedes the parked one, including on the drain cycle itself
            if (w_redirect) begin
               flush   = 1'b1;
               w_latch = 1'b1;
            end else begin
               pc_offset = r_pend_off;
               pc_jval   = r_pend_jval;
            end
            if (imem_ack) begin
               pc_hold   = 1'b0;
               pc_branch = w_redirect ? br_taken : r_pend_br;
               pc_jump   = w_redirect ? ~br_taken : ~r_pend_br;
               w_clear   = 1'b1;
               w_next    = S_REQ;
            end
         end
         default: w_next = S_RESET;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_RESET;
         r_pend_br   <= 1'b0;
         r_pend_off  <= '0;
         r_pend_jval <= '0;
         r_cnt       <= '0;
         r_err       <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_clear) begin
            r_pend_br   <= 1'b0;
            r_pend_off  <= '0;
            r_pend_jval <= '0;
         end else if (w_latch) begin
            r_pend_br   <= br_taken;
            r_pend_off  <= br_offset;
            r_pend_jval <= jmp_target;
         end
         if (r_cnt == CNT_MAX) r_err <= 1'b1;
         if (imem_req && !imem_ack) begin
            if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
         end else begin
            r_cnt <= '0;
         end
      end
   end

endmodule
